// File: rtl/td4_exec_ctrl.sv
// rtl/td4_exec_ctrl.sv - TD4 decode, ALU operand select and single-cycle writeback of A/B/OUT/PC/carry.
// Optional halt-on-self-jump detection is enabled by defining HALT_DETECT_EN.
module td4_exec_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N+3:0]   instr,
  input  logic [N-1:0]   in_port,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_y,
  input  logic           alu_c,
  output logic [N-1:0]   pc,
  output logic [N-1:0]   reg_a,
  output logic [N-1:0]   reg_b,
  output logic [N-1:0]   out_port,
  output logic           carry,
  output logic           halted
);

  typedef enum logic [2:0] {
    DST_NONE,
    DST_A,
    DST_B,
    DST_OUT,
    DST_PC
  } dst_t;

  logic [3:0] opcode;
  dst_t       dst;
  logic       step;

  assign opcode = instr[N+3:N];
  assign alu_b  = instr[N-1:0];

  always_comb begin
    alu_a = '0;
    dst   = DST_NONE;
    case (opcode)
      4'b0000: begin alu_a = reg_a;   dst = DST_A;   end
      4'b0011: begin                  dst = DST_A;   end
      4'b0001: begin alu_a = reg_b;   dst = DST_A;   end
      4'b0010: begin alu_a = in_port; dst = DST_A;   end
      4'b0101: begin alu_a = reg_b;   dst = DST_B;   end
      4'b0111: begin                  dst = DST_B;   end
      4'b0100: begin alu_a = reg_a;   dst = DST_B;   end
      4'b0110: begin alu_a = in_port; dst = DST_B;   end
      4'b1001: begin alu_a = reg_b;   dst = DST_OUT; end
      4'b1011: begin                  dst = DST_OUT; end
      4'b1111: begin                  dst = DST_PC;  end
      // JNC looks at the flag left by the previous instruction
      4'b1110: begin                  dst = carry ? DST_NONE : DST_PC; end
      default: begin end
    endcase
  end

  // A halted core ignores en entirely; only rst brings it back
  assign step = en && !halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
    end else if (step) begin
      carry <= alu_c;
      pc    <= (dst == DST_PC) ? alu_y : pc + N'(1);
      case (dst)
        DST_A:   reg_a    <= alu_y;
        DST_B:   reg_b    <= alu_y;
        DST_OUT: out_port <= alu_y;
        default: begin end
      endcase
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (step && (dst == DST_PC) && (alu_y == pc)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// tb/tb_td4_exec_ctrl.sv - scoreboard bench for td4_exec_ctrl with an instruction-level reference model.
module tb_td4_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [7:0] instr = 8'h00;
  logic [3:0] in_port = 4'h0;
  logic [3:0] alu_a, alu_b, alu_y, pc, reg_a, reg_b, out_port;
  logic       alu_c, carry, halted;
  logic [4:0] alu_sum;

  td4_exec_ctrl #(.N(4)) dut (
    .clk(clk), .rst(rst), .en(en), .instr(instr), .in_port(in_port),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_c(alu_c),
    .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .out_port(out_port),
    .carry(carry), .halted(halted)
  );

  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_y   = alu_sum[3:0];
  assign alu_c   = alu_sum[4];

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pc, a, b, o, c, h;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 0;

  int m_pc = 0, m_a = 0, m_b = 0, m_o = 0, m_c = 0, m_h = 0;
  int step_id = 0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, id, act, exp);
    end
  endtask

  // Architectural effect of one clock edge, straight from the instruction table
  task automatic issue(input bit r, input bit e, input logic [7:0] ins, input logic [3:0] inp);
    int op, im, src, sum, y, cy;
    bit jump;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; instr = ins; in_port = inp;
    op = int'(ins[7:4]);
    im = int'(ins[3:0]);
    if (r) begin
      m_pc = 0; m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_h = 0;
    end else if (e && m_h == 0) begin
      case (op)
        0, 4:    src = m_a;
        1, 5, 9: src = m_b;
        2, 6:    src = int'(inp);
        default: src = 0;
      endcase
      sum  = src + im;
      y    = sum % 16;
      cy   = sum / 16;
      jump = (op == 15) || (op == 14 && m_c == 0);
`ifdef HALT_DETECT_EN
      if (jump && y == m_pc) m_h = 1;
`endif
      case (op)
        0, 1, 2, 3: m_a = y;
        4, 5, 6, 7: m_b = y;
        9, 11:      m_o = y;
        default: ;
      endcase
      m_pc = jump ? y : (m_pc + 1) % 16;
      m_c  = cy;
    end
    x.id = step_id; x.pc = m_pc; x.a = m_a; x.b = m_b; x.o = m_o; x.c = m_c; x.h = m_h;
    q.push_back(x);
    step_id++;
  endtask

  initial begin
    // reset wins over en
    issue(1, 1, 8'h35, 4'h0);
    issue(0, 1, 8'h33, 4'h0);
    issue(0, 1, 8'h0F, 4'h0);
    issue(0, 1, 8'hE9, 4'h0);
    issue(0, 1, 8'h75, 4'h0);
    issue(0, 1, 8'h90, 4'h0);
    issue(0, 1, 8'hE9, 4'h0);
    issue(0, 1, 8'h20, 4'hA);
    issue(0, 1, 8'h41, 4'hA);
    for (int i = 0; i < 3; i++) issue(0, 0, 8'h0F, 4'h3);
    issue(0, 1, 8'hFF, 4'h0);
    issue(0, 1, 8'h80, 4'h0);
    issue(0, 1, 8'hF6, 4'h0);
    issue(0, 1, 8'hF6, 4'h0);
    issue(0, 1, 8'h31, 4'h0);
    issue(0, 0, 8'h31, 4'h0);
    issue(1, 0, 8'h00, 4'h0);
    for (int i = 0; i < 600; i++) begin
      issue(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
            8'($urandom), 4'($urandom));
    end
    @(negedge clk);
    en = 1'b0;
    stim_done = 1;
  end

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("pc",       x.id, int'(pc),       x.pc);
        chk("reg_a",    x.id, int'(reg_a),    x.a);
        chk("reg_b",    x.id, int'(reg_b),    x.b);
        chk("out_port", x.id, int'(out_port), x.o);
        chk("carry",    x.id, int'(carry),    x.c);
        chk("halted",   x.id, int'(halted),   x.h);
      end
    end
  end

  initial begin
    fork
      wait (stim_done);
      #200000;
    join_any
    disable fork;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (!stim_done || q.size() != 0) begin
      bad++;
      $display("FAIL drain stim_done=%0d pending=%0d expected done with 0 pending", stim_done, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
